cfar_fil_stream_ctrl: RTL and testbench
=======================================

# cfar_fil_stream_ctrl

FPGA-side driver/collector for the CFAR FIL word interface: the other end of the 40-bit `din` / 56-bit `dout` packing used by the CFAR DUT FIL wrapper. It takes a handshaked stream of power samples, frames them into `din` words (power in bits 28:0, valid in bit 32), and decodes returned `dout` words, queuing each reported maximum (index, value) in a small result FIFO for the host. It sits between the host sample/result channels and the FIL wrapper.

## Interface
- `FRAME_LEN`, 512: samples per frame; range 1..512.
- `RES_DEPTH`, 8: result FIFO depth; power of two, 2..64.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse in IDLE begins one frame; ignored in other states.
- `gap_cycles`  in  8  idle cycles after a frame; latched on accepted `start`.
- `s_power`  in  29  unsigned power sample.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  sample accepted when `s_valid & s_ready`.
- `din`  out  40  word to the FIL wrapper: [28:0] power, [32] valid, all other bits 0.
- `dout`  in  56  word from the FIL wrapper: [8:0] index, [44:16] max value, [48] max valid; [15:9], [47:45], [55:49] reserved (0).
- `m_index`  out  9  head result index.
- `m_max`  out  29  head result max value.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  pop head when `m_valid & m_ready`.
- `busy`  out  1  high in STREAM or GAP.
- `frame_done`  out  1  one-cycle pulse on return to IDLE.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `proto_err`  out  1  sticky: a reserved `dout` bit was 1 while `dout[48]` was 1.

## Operation
- TX states: IDLE, STREAM, GAP. Sample counter 0..FRAME_LEN-1; gap counter 8 bits.
- IDLE: `s_ready`=0. On `start`: latch `gap_cycles`, clear sample counter, clear `overflow` and `proto_err`, go to STREAM.
- STREAM: `s_ready`=1. Each accepted sample increments the counter; acceptance at count FRAME_LEN-1 leaves STREAM: to GAP if latched gap > 0, else to IDLE with `frame_done`.
- GAP: `s_ready`=0; stays exactly latched-gap cycles, then IDLE with `frame_done`.
- `din` is registered: cycle after acceptance, `din[28:0]`=sample and `din[32]`=1; in any cycle without acceptance, `din`=0 (valid and power both cleared). Stalls (`s_valid`=0) in STREAM produce `din`=0 bubbles.
- RX runs in every state, independent of TX: `dout` registered every cycle; when the registered word has bit 48 set, push {index, max} into the FIFO.
- Push with FIFO full and no simultaneous pop: drop the result, set `overflow`. Push and pop in the same cycle when full: both happen, no overflow.
- Reserved-bit check only on words with bit 48 set; result still pushed.
- Sticky flags clear only on `reset` or accepted `start`.

## Timing
- Reset values: `s_ready`=0, `din`=0, `m_valid`=0, `m_index`=0, `m_max`=0, `busy`=0, `frame_done`=0, `overflow`=0, `proto_err`=0; state IDLE, FIFO empty.
- `start` at cycle t: `busy` and `s_ready` high at t+1.
- Sample accepted at cycle t: on `din` during t+1.
- `dout[48]` high at cycle t: `m_valid` high at t+2 (input register, then FIFO write); FIFO is first-word-fall-through, head data combinational from storage.
- `frame_done` asserted the cycle state is IDLE again; `busy` low in that same cycle.
- `reset` mid-frame or with FIFO data: immediately returns all state to reset values; pending results lost.

## Structure
- Package `cfar_fil_pkg`: bit positions/widths of `din` and `dout` fields (power 28:0, valid 32, index 8:0, max 44:16, max-valid 48, reserved masks), POWER_W=29, INDEX_W=9, TX state enum.
- Sub-module `cfar_fil_result_fifo`: parameterised FIFO (width 38, depth RES_DEPTH) with full/empty, FWFT read; top holds TX FSM, RX decode and flags.

## Test plan
- Reset then `start`, FRAME_LEN=4, gap 2, samples 10,20,30,40 back-to-back -> `din` = 0x1_0000000A, 0x1_00000014, 0x1_0000001E, 0x1_00000028 on consecutive cycles; GAP 2 cycles; `frame_done` once; `busy` low.
- Same frame with `s_valid` low every other cycle -> `din`=0 on bubble cycles, exactly 4 valid words, order preserved.
- Drive `dout` with bit48=1, index 0x1A5, max 0x1234567 -> `m_valid` 2 cycles later, `m_index`=0x1A5, `m_max`=0x1234567; pop with `m_ready` -> `m_valid`=0.
- RES_DEPTH=8, `m_ready`=0, 10 consecutive result words -> first 8 held in order, `overflow`=1; next `start` clears it.
- Result word with bit 55 set -> `proto_err`=1, result still queued; `start` with gap 0 -> STREAM straight to IDLE, `frame_done` once.
- Assert `reset` mid-STREAM with 3 results queued -> next cycle all outputs at reset values, `m_valid`=0, `din`=0.

Source files
------------

// File: rtl/cfar_fil_pkg.sv
// cfar_fil_pkg: field layout of the FIL din/dout words and the TX state encoding.
package cfar_fil_pkg;
    localparam int DIN_W         = 40;
    localparam int DOUT_W        = 56;
    localparam int POWER_W       = 29;
    localparam int INDEX_W       = 9;
    localparam int RES_W         = INDEX_W + POWER_W;
    localparam int DIN_VALID_BIT = 32;
    localparam int DOUT_IDX_LSB  = 0;
    localparam int DOUT_MAX_LSB  = 16;
    localparam int DOUT_MV_BIT   = 48;
    // Reserved dout bits [15:9], [47:45], [55:49]
    localparam logic [DOUT_W-1:0] DOUT_RSVD_MASK = 56'hFE_E000_0000_FE00;

    typedef enum logic [1:0] {TX_IDLE, TX_STREAM, TX_GAP} tx_state_e;

    function automatic logic [DIN_W-1:0] pack_din(input logic [POWER_W-1:0] power);
        logic [DIN_W-1:0] d;
        d = '0;
        d[POWER_W-1:0] = power;
        d[DIN_VALID_BIT] = 1'b1;
        return d;
    endfunction
endpackage

// File: rtl/cfar_fil_stream_ctrl_if.sv
// cfar_fil_stream_ctrl_if: sample stream, result stream and FIL word bundle.
interface cfar_fil_stream_ctrl_if;
    import cfar_fil_pkg::*;
    logic [POWER_W-1:0] s_power;
    logic               s_valid;
    logic               s_ready;
    logic [DIN_W-1:0]   din;
    logic [DOUT_W-1:0]  dout;
    logic [INDEX_W-1:0] m_index;
    logic [POWER_W-1:0] m_max;
    logic               m_valid;
    logic               m_ready;
    modport slave (input s_power, s_valid, dout, m_ready, output s_ready, din, m_index, m_max, m_valid);
    modport master (output s_power, s_valid, dout, m_ready, input s_ready, din, m_index, m_max, m_valid);
endinterface

// File: rtl/cfar_fil_result_fifo.sv
// cfar_fil_result_fifo: first-word-fall-through FIFO; a write into a full FIFO lands only with a simultaneous read.
module cfar_fil_result_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    logic         do_wr, do_rd;
    assign empty   = wp_q == rp_q;
    assign full    = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rp_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp_q[AW-1:0]] <= wr_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_wr) wp_q <= wp_q + 1'b1;
            if (do_rd) rp_q <= rp_q + 1'b1;
        end
    end
endmodule

// File: rtl/cfar_fil_stream_ctrl.sv
// cfar_fil_stream_ctrl: frames host samples into FIL din words and queues dout maxima for the host.
module cfar_fil_stream_ctrl
    import cfar_fil_pkg::*;
#(
    parameter int FRAME_LEN = 512,
    parameter int RES_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             gap_cycles,
    cfar_fil_stream_ctrl_if.slave  bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   proto_err
);
    localparam int CNT_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    tx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         gap_q;
    logic [DIN_W-1:0]   din_q;
    logic [DOUT_W-1:0]  dout_q;
    logic               frame_done_q, overflow_q, proto_err_q;
    logic               accept, clear, push, pop, full, empty;
    logic [RES_W-1:0]   head;

    assign accept = state_q == TX_STREAM && bus.s_valid;
    assign clear  = state_q == TX_IDLE && start;
    assign push   = dout_q[DOUT_MV_BIT];
    assign pop    = bus.m_ready && !empty;

    // gap_q doubles as the GAP down-counter once the frame has been streamed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= TX_IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            din_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            din_q        <= accept ? pack_din(bus.s_power) : '0;
            case (state_q)
                TX_IDLE: if (start) begin
                    gap_q   <= gap_cycles;
                    cnt_q   <= '0;
                    state_q <= TX_STREAM;
                end
                TX_STREAM: if (accept) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q      <= gap_q != 8'd0 ? TX_GAP : TX_IDLE;
                        frame_done_q <= gap_q == 8'd0;
                    end
                end
                TX_GAP: if (gap_q == 8'd1) begin
                    state_q      <= TX_IDLE;
                    frame_done_q <= 1'b1;
                end else begin
                    gap_q <= gap_q - 8'd1;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            dout_q      <= bus.dout;
            overflow_q  <= (overflow_q && !clear) || (push && full && !pop);
            proto_err_q <= (proto_err_q && !clear) || (push && |(dout_q & DOUT_RSVD_MASK));
        end
    end

    cfar_fil_result_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({dout_q[DOUT_IDX_LSB +: INDEX_W], dout_q[DOUT_MAX_LSB +: POWER_W]}),
        .rd_en   (bus.m_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign bus.s_ready = state_q == TX_STREAM;
    assign bus.din     = din_q;
    assign bus.m_valid = !empty;
    assign bus.m_index = head[RES_W-1:POWER_W];
    assign bus.m_max   = head[POWER_W-1:0];
    assign busy        = state_q != TX_IDLE;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_cfar_fil_stream_ctrl.sv
// tb_cfar_fil_stream_ctrl: directed stimulus with scoreboard queues for din words and FIFO results.
module tb_cfar_fil_stream_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] gap_cycles = 8'd0;
    logic       busy, frame_done, overflow, proto_err;
    int         checks = 0;
    int         errors = 0;
    int         din_cnt = 0;
    int         fd_cnt = 0;
    logic [39:0] exp_din [$];
    logic [37:0] exp_res [$];

    cfar_fil_stream_ctrl_if bus ();

    cfar_fil_stream_ctrl #(.FRAME_LEN(4), .RES_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .gap_cycles (gap_cycles),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] din_word(input logic [28:0] p);
        return {7'd0, 1'b1, 3'd0, p};
    endfunction

    function automatic logic [55:0] mk(input logic [8:0] idx, input logic [28:0] mx, input logic r55);
        return {r55, 6'd0, 1'b1, 3'd0, mx, 7'd0, idx};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (bus.din[32]) begin
                din_cnt++;
                if (exp_din.size() == 0) chk("din_unexpected", bus.din, 40'd0);
                else chk("din_word", bus.din, exp_din.pop_front());
            end else begin
                chk("din_idle", bus.din, 40'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (exp_res.size() == 0) begin
                chk("res_unexpected", {bus.m_index, bus.m_max}, 38'd0);
            end else begin
                logic [37:0] e;
                e = exp_res.pop_front();
                chk("res_index", bus.m_index, e[37:29]);
                chk("res_max", bus.m_max, e[28:0]);
            end
        end
    end

    task automatic run_frame(input logic [7:0] gap, input bit bubble);
        int n, fd0, d0;
        fd0 = fd_cnt;
        d0 = din_cnt;
        start = 1'b1;
        gap_cycles = gap;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("s_ready_after_start", bus.s_ready, 1);
        for (int i = 0; i < 4; i++) begin
            if (bubble) begin
                bus.s_valid = 1'b0;
                tick();
            end
            bus.s_valid = 1'b1;
            bus.s_power = 29'(10 * (i + 1));
            exp_din.push_back(din_word(29'(10 * (i + 1))));
            tick();
        end
        bus.s_valid = 1'b0;
        n = 0;
        while (!frame_done && n < 50) begin
            if (n == 0) chk("s_ready_in_gap", bus.s_ready, 0);
            tick();
            n++;
        end
        chk("gap_cycles_to_done", n, gap);
        chk("busy_at_done", busy, 0);
        tick();
        tick();
        chk("frame_done_pulses", fd_cnt - fd0, 1);
        chk("din_valid_words", din_cnt - d0, 4);
        chk("din_queue_drained", exp_din.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.s_power = '0;
        bus.s_valid = 1'b0;
        bus.dout = '0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_index", bus.m_index, 0);
        chk("rst_m_max", bus.m_max, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_proto_err", proto_err, 0);

        run_frame(8'd2, 1'b0);
        run_frame(8'd2, 1'b1);

        bus.dout = mk(9'h1A5, 29'h1234567, 1'b0);
        tick();
        bus.dout = '0;
        chk("res_latency_not_yet", bus.m_valid, 0);
        tick();
        chk("res_m_valid", bus.m_valid, 1);
        chk("res_head_index", bus.m_index, 9'h1A5);
        chk("res_head_max", bus.m_max, 29'h1234567);
        exp_res.push_back({9'h1A5, 29'h1234567});
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("res_popped", bus.m_valid, 0);

        for (int i = 0; i < 10; i++) begin
            bus.dout = mk(9'(i), 29'(100 + i), 1'b0);
            if (i < 8) exp_res.push_back({9'(i), 29'(100 + i)});
            tick();
        end
        bus.dout = '0;
        tick();
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_head_first", bus.m_index, 9'd0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        bus.m_ready = 1'b0;
        chk("ovf_drained", bus.m_valid, 0);
        chk("ovf_res_queue", exp_res.size(), 0);

        bus.dout = mk(9'd3, 29'd7, 1'b1);
        tick();
        bus.dout = '0;
        tick();
        chk("proto_err_set", proto_err, 1);
        chk("proto_res_queued", bus.m_valid, 1);
        chk("ovf_still_set", overflow, 1);
        exp_res.push_back({9'd3, 29'd7});
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        run_frame(8'd0, 1'b0);
        chk("start_clears_ovf", overflow, 0);
        chk("start_clears_proto", proto_err, 0);

        start = 1'b1;
        gap_cycles = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dout = mk(9'(i), 29'(i), 1'b0);
            tick();
        end
        bus.dout = '0;
        tick();
        tick();
        chk("pre_rst_m_valid", bus.m_valid, 1);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #2;
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_din", bus.din, 0);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_m_index", bus.m_index, 0);
        chk("mid_rst_m_max", bus.m_max, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_proto_err", proto_err, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_m_valid", bus.m_valid, 0);
        chk("post_rst_busy", busy, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
